grant_sched8: RTL and testbench

GRANT_SCHED8 -- requirements
Module: grant_sched8

---
 rtl/grant_sched8.sv | 144 ++++++++++++++
 tb/tb_grant_sched8.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/grant_sched8.sv
// grant_sched8: 8-requester round-robin grant scheduler.
//
// Two-state FSM (IDLE / GRANT) with all outputs registered. A 3-bit priority
// pointer sets the search order ptr, ptr+1, ..., ptr+7 (mod 8). A grant is held
// while its request stays high. On release the pointer moves past the
// releasing index and the grant hands off directly to the next requester.
//
// Optional feature (macro ARB_TIMEOUT_EN): an 8-bit hold counter forces
// rotation after HOLD_MAX cycles when another requester is waiting. A tmo
// pulse marks each forced rotation.
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles before forced rotation
//             (ARB_TIMEOUT_EN only), legal range 1..255
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   req      [7:0] level-sensitive request vector
//   gnt      [7:0] one-hot registered grant
//   gnt_idx  [2:0] index of current grantee (holds when gnt_vld is low)
//   gnt_vld  any grant active (equals |gnt)
//   tmo      one-cycle forced-rotation pulse (ARB_TIMEOUT_EN only)
module grant_sched8 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld
`ifdef ARB_TIMEOUT_EN
    ,
    output logic       tmo
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
`endif

    logic [7:0] avail;
    logic [2:0] base;
    logic       win_found;
    logic [2:0] win_idx;
    logic       held;

    // First set bit of r, scanning from index p upward with wrap.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] k;
        res = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            k = p + 3'(i);
            if (!res[3] && r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    // In GRANT, the search always starts just past the holder and excludes it.
    // This covers both the release handoff and the forced rotation.
    always_comb begin
        avail = req;
        base  = ptr;
        if (state == GRANT) begin
            avail = req & ~(8'(1) << gnt_idx);
            base  = gnt_idx + 3'd1;
        end
        {win_found, win_idx} = pick(avail, base);
        held = req[gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            ptr     <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
            tmo      <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            tmo <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state   <= GRANT;
                        gnt     <= 8'(1) << win_idx;
                        gnt_idx <= win_idx;
                        gnt_vld <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!held) begin
                        ptr <= gnt_idx + 3'd1;
                        if (win_found) begin
                            gnt     <= 8'(1) << win_idx;
                            gnt_idx <= win_idx;
                        end else begin
                            state   <= IDLE;
                            gnt     <= '0;
                            gnt_vld <= 1'b0;
                        end
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    // The counter tracks completed grant cycles, so the
                    // HOLD_MAX-th cycle is the last one the holder keeps.
                    else if (hold_cnt == 8'(HOLD_MAX - 1)) begin
                        hold_cnt <= '0;
                        if (win_found) begin
                            ptr     <= gnt_idx + 3'd1;
                            gnt     <= 8'(1) << win_idx;
                            gnt_idx <= win_idx;
                            tmo     <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grant_sched8.sv
// tb_grant_sched8: self-checking bench for grant_sched8.
// Table-driven directed vectors plus hand-written hold / timeout sequences.
// Expected outputs are queued when each input is driven and popped after the
// next rising edge. Build with +define+ARB_TIMEOUT_EN to cover the timeout.
module tb_grant_sched8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
`ifdef ARB_TIMEOUT_EN
    logic       tmo;
`endif

    grant_sched8 #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
`ifdef ARB_TIMEOUT_EN
        ,
        .tmo     (tmo)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       tmo;
    } vec_t;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       tmo;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int tag, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, tag, act, want);
        end
    endtask

    // Drive one cycle of input, queue its expectation, and compare after the edge.
    task automatic step(input logic r, input logic [7:0] q, input logic [7:0] eg,
                        input logic [2:0] ei, input logic ev, input logic et, input int tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = q;
        sb.push_back('{gnt: eg, idx: ei, vld: ev, tmo: et, tag: tag});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard empty at step %0d", tag);
        end else begin
            e = sb.pop_front();
            chk("gnt", e.tag, int'(gnt), int'(e.gnt));
            chk("gnt_vld", e.tag, int'(gnt_vld), int'(e.vld));
            if (e.vld) chk("gnt_idx", e.tag, int'(gnt_idx), int'(e.idx));
            else       chk("gnt_idx_hold", e.tag, int'(gnt_idx), int'(e.idx));
`ifdef ARB_TIMEOUT_EN
            chk("tmo", e.tag, int'(tmo), int'(e.tmo));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // {rst, req, gnt, idx, vld, tmo}
        vecs.push_back('{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0}); // reset, req ignored
        vecs.push_back('{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0}); // req 0 first after reset
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}); // release, ptr=1
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0}); // single request
        vecs.push_back('{1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0}); // drop, idx holds
        vecs.push_back('{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}); // ptr back to 0
        vecs.push_back('{1'b0, 8'h91, 8'h01, 3'd0, 1'b1, 1'b0}); // round robin 0
        vecs.push_back('{1'b0, 8'h90, 8'h10, 3'd4, 1'b1, 1'b0}); // handoff 4
        vecs.push_back('{1'b0, 8'h91, 8'h10, 3'd4, 1'b1, 1'b0}); // 0 back, ordered behind
        vecs.push_back('{1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0}); // handoff 7
        vecs.push_back('{1'b0, 8'h91, 8'h80, 3'd7, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h11, 8'h01, 3'd0, 1'b1, 1'b0}); // handoff 0 (wraps)
        vecs.push_back('{1'b0, 8'h11, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0}); // ptr=5
        vecs.push_back('{1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0}); // ptr=7
        vecs.push_back('{1'b0, 8'h41, 8'h01, 3'd0, 1'b1, 1'b0}); // wrap: 0 before 6
        vecs.push_back('{1'b0, 8'h41, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0}); // ptr=7
        vecs.push_back('{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'h08, 8'h00, 3'd0, 1'b0, 1'b0}); // reset mid-grant
        vecs.push_back('{1'b0, 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0}); // ptr back to 0
        vecs.push_back('{1'b0, 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0}); // search from 4 wraps to 2
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0}); // ptr=3
        vecs.push_back('{1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0}); // other bits don't disturb
        vecs.push_back('{1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].idx, vecs[i].vld, vecs[i].tmo, i);

        // Constant competing request after reset: requester 0 first.
        step(1'b1, 8'h03, 8'h00, 3'd0, 1'b0, 1'b0, 100);
`ifdef ARB_TIMEOUT_EN
        // HOLD_MAX=4: alternate every 4 cycles, tmo at each switch.
        for (int k = 0; k < 16; k++) begin
            logic [7:0] eg;
            eg = ((k / 4) % 2 == 1) ? 8'h02 : 8'h01;
            step(1'b0, 8'h03, eg, (eg == 8'h02) ? 3'd1 : 3'd0, 1'b1,
                 (k > 0 && k % 4 == 0), 200 + k);
        end
        // Lone requester keeps the grant, no tmo.
        step(1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0, 300);
        for (int k = 0; k < 12; k++)
            step(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0, 301 + k);
`else
        // Without timeout the holder keeps the grant indefinitely.
        for (int k = 0; k < 16; k++)
            step(1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0, 200 + k);
`endif
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 400);

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard leftover: %0d entries, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
